// File: rtl/prog_loader.sv
// prog_loader: 2048x14 writable program memory loaded from a byte stream.
// Optional trailing checksum byte when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [10:0] addr_in,
  output logic [13:0] data_out,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [10:0] wr_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_CHK,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_lo_q, cnt_lo_d;
  logic [11:0] remain_q, remain_d;
  logic [7:0]  lo_q, lo_d;
  logic [10:0] wr_addr_q, wr_addr_d;
  logic        err_q, err_d;
  logic        we;
  logic [13:0] wdata;
  logic [11:0] count;
  logic        fire;
  state_t      end_st;

  logic [13:0] mem [2048];

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
  assign end_st = S_CHK;
`else
  assign end_st = S_DONE;
`endif

  // Handshake and status are pure decodes of the state.
  always_comb begin
    busy     = (state_q != S_IDLE) && (state_q != S_DONE);
    rx_ready = busy;
    done     = (state_q == S_DONE);
    err      = err_q;
    wr_addr  = wr_addr_q;
    data_out = mem[addr_in];
  end

  // Next-state, header/word assembly and write strobe.
  always_comb begin
    state_d   = state_q;
    cnt_lo_d  = cnt_lo_q;
    remain_d  = remain_q;
    lo_d      = lo_q;
    wr_addr_d = wr_addr_q;
    err_d     = err_q;
    we        = 1'b0;
    wdata     = {rx_data[5:0], lo_q};
    count     = {rx_data[3:0], cnt_lo_q};
    fire      = rx_valid && rx_ready;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_CNT_LO;
          err_d     = 1'b0;
          wr_addr_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d     = '0;
`endif
        end
      end
      S_CNT_LO: begin
        if (fire) begin
          cnt_lo_d = rx_data;
          state_d  = S_CNT_HI;
        end
      end
      S_CNT_HI: begin
        if (fire) begin
          remain_d = count;
          if (count == 12'd0) begin
            state_d = end_st;
          end else if (count > 12'd2048) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_DATA_LO;
          end
        end
      end
      S_DATA_LO: begin
        if (fire) begin
          lo_d    = rx_data;
          state_d = S_DATA_HI;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d   = sum_q + rx_data;
`endif
        end
      end
      S_DATA_HI: begin
        if (fire) begin
          we        = 1'b1;
          wr_addr_d = wr_addr_q + 11'd1;
          remain_d  = remain_q - 12'd1;
          if (rx_data[7:6] != 2'b00) err_d = 1'b1;
          state_d   = (remain_q == 12'd1) ? end_st : S_DATA_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_d     = sum_q + rx_data;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK: begin
        if (fire) begin
          if (rx_data != sum_q) err_d = 1'b1;
          state_d = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_lo_q  <= '0;
      remain_q  <= '0;
      lo_q      <= '0;
      wr_addr_q <= '0;
      err_q     <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_lo_q  <= cnt_lo_d;
      remain_q  <= remain_d;
      lo_q      <= lo_d;
      wr_addr_q <= wr_addr_d;
      err_q     <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  // Memory array keeps contents across reset; a reset edge blocks the write.
  always_ff @(posedge clk) begin
    if (we && !rst) mem[wr_addr_q] <= wdata;
  end

endmodule
